// File: rtl/rr_arbiter_83.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter_83
// Purpose  : 8-way arbiter with selectable fixed-priority / round-robin
//            winner selection and a hold counter that forces re-arbitration
//            when one owner keeps the grant while others are waiting.
// Ports    : clk    - clock, all state updates on rising edge
//            rst    - asynchronous active-high reset
//            en     - enable; 0 blocks new grants and revokes the active one
//            mode   - 0 fixed priority (index 7 highest), 1 round-robin
//            req    - request lines, held until served
//            done   - one-cycle pulse from the current owner ending its grant
//            gnt    - one-hot registered grant
//            gnt_id - registered binary index of the granted requester
//            v      - grant valid (gnt nonzero)
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter_83 #(
    parameter int HOLD_MAX = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       mode,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       v
);

    localparam int              c_CNT_W   = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(HOLD_MAX - 1);

    localparam logic [0:0] c_IDLE  = 1'b0;
    localparam logic [0:0] c_GRANT = 1'b1;

    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [7:0]         r_gnt;
    logic [2:0]         r_gnt_id;
    logic               r_v;
    logic [c_CNT_W-1:0] r_cnt;
    logic [2:0]         r_last_id;

    logic [7:0]         w_gnt_d;
    logic [2:0]         w_gnt_id_d;
    logic               w_v_d;
    logic [c_CNT_W-1:0] w_cnt_d;
    logic [2:0]         w_last_id_d;

    logic [2:0]         w_fp_id;
    logic [2:0]         w_rr_id;
    logic               w_rr_found;
    logic [2:0]         w_win;
    logic               w_start;
    logic               w_release;

    // Fixed priority: the loop leaves the highest set index in w_fp_id.
    always_comb begin
        w_fp_id = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (req[i]) w_fp_id = 3'(i);
        end
    end

    // Round-robin: scan last_id+1 .. last_id+8 (mod 8); the last step lands
    // back on last_id itself so a lone repeat requester is still served.
    always_comb begin
        logic [2:0] idx;
        w_rr_found = 1'b0;
        w_rr_id    = 3'd0;
        idx        = 3'd0;
        for (int i = 1; i <= 8; i++) begin
            idx = r_last_id + 3'(i);
            if (!w_rr_found && req[idx]) begin
                w_rr_found = 1'b1;
                w_rr_id    = idx;
            end
        end
    end

    // mode only matters here, i.e. while IDLE picks a new owner.
    assign w_win   = mode ? w_rr_id : w_fp_id;
    assign w_start = en && (req != 8'h00);

    // Forced release at the hold limit only when someone else is waiting.
    assign w_release = done || !req[r_gnt_id] || !en ||
                       ((r_cnt == c_CNT_MAX) && ((req & ~r_gnt) != 8'h00));

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= c_IDLE;
        else     r_state <= w_state_nxt;
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (w_start)   w_state_nxt = c_GRANT;
            c_GRANT: if (w_release) w_state_nxt = c_IDLE;
            default:                w_state_nxt = c_IDLE;
        endcase
    end

    // --------------------------------------------------------------- output
    // Computes the values the output/bookkeeping registers take next edge.
    always_comb begin
        w_gnt_d     = 8'h00;
        w_gnt_id_d  = 3'd0;
        w_v_d       = 1'b0;
        w_cnt_d     = '0;
        w_last_id_d = r_last_id;
        case (r_state)
            c_IDLE: begin
                if (w_start) begin
                    w_gnt_d     = 8'b1 << w_win;
                    w_gnt_id_d  = w_win;
                    w_v_d       = 1'b1;
                    w_last_id_d = w_win;
                end
            end
            c_GRANT: begin
                if (!w_release) begin
                    w_gnt_d    = r_gnt;
                    w_gnt_id_d = r_gnt_id;
                    w_v_d      = 1'b1;
                    w_cnt_d    = (r_cnt == c_CNT_MAX) ? r_cnt : r_cnt + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gnt     <= 8'h00;
            r_gnt_id  <= 3'd0;
            r_v       <= 1'b0;
            r_cnt     <= '0;
            r_last_id <= 3'd7;
        end else begin
            r_gnt     <= w_gnt_d;
            r_gnt_id  <= w_gnt_id_d;
            r_v       <= w_v_d;
            r_cnt     <= w_cnt_d;
            r_last_id <= w_last_id_d;
        end
    end

    assign gnt    = r_gnt;
    assign gnt_id = r_gnt_id;
    assign v      = r_v;

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter_83.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_arbiter_83
// Purpose  : Directed self-checking bench for rr_arbiter_83 (HOLD_MAX=4).
//            Expected outputs are queued as stimulus is applied and popped
//            after each clock edge (or immediately for async reset checks).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_arbiter_83;

    localparam int HM = 4;

    logic       clk;
    logic       rst;
    logic       en;
    logic       mode;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       v;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string      tag;
        logic [7:0] gnt;
        logic [2:0] id;
        logic       v;
    } exp_t;

    exp_t sb[$];

    rr_arbiter_83 #(.HOLD_MAX(HM)) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .mode  (mode),
        .req   (req),
        .done  (done),
        .gnt   (gnt),
        .gnt_id(gnt_id),
        .v     (v)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Queue an expectation: a valid grant of id, or no grant.
    task automatic expect_out(input string tag, input logic [2:0] id, input logic vld);
        exp_t e;
        e.tag = tag;
        e.v   = vld;
        e.id  = vld ? id : 3'd0;
        e.gnt = vld ? (8'b1 << id) : 8'h00;
        sb.push_back(e);
    endtask

    // Pop the oldest expectation and compare against current outputs.
    task automatic check_now();
        exp_t e;
        checks++;
        assert (sb.size() != 0) else begin
            failures++;
            $error("FAIL scoreboard_empty observed=0 expected=nonzero entries");
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            assert (gnt === e.gnt) else begin
                failures++;
                $error("FAIL %s gnt observed=%h expected=%h", e.tag, gnt, e.gnt);
            end
            checks++;
            assert (gnt_id === e.id) else begin
                failures++;
                $error("FAIL %s gnt_id observed=%0d expected=%0d", e.tag, gnt_id, e.id);
            end
            checks++;
            assert (v === e.v) else begin
                failures++;
                $error("FAIL %s v observed=%b expected=%b", e.tag, v, e.v);
            end
        end
    endtask

    // One clock: queue expectation for post-edge outputs, sample 1 ns later.
    task automatic step(input string tag, input logic [2:0] id, input logic vld);
        expect_out(tag, id, vld);
        @(posedge clk);
        #1;
        check_now();
    endtask

    initial begin
        rst  = 1'b0;
        en   = 1'b0;
        mode = 1'b0;
        req  = 8'h00;
        done = 1'b0;

        // Reset state, asynchronously applied before any clock edge.
        #2 rst = 1'b1;
        #1;
        expect_out("reset_init", 3'd0, 1'b0);
        check_now();
        step("reset_hold", 3'd0, 1'b0);

        // Fixed priority: highest set index wins.
        rst  = 1'b0;
        mode = 1'b0;
        en   = 1'b1;
        req  = 8'b0010_1010;
        step("fp_pick5", 3'd5, 1'b1);
        req  = 8'h00;
        step("fp_release", 3'd0, 1'b0);

        // Reset mid-grant drops outputs without a clock edge.
        req = 8'h08;
        step("pre_reset_grant", 3'd3, 1'b1);
        rst = 1'b1;
        #1;
        expect_out("async_reset", 3'd0, 1'b0);
        check_now();
        step("reset_held_edge", 3'd0, 1'b0);

        // After reset last_id=7, so round-robin starts at 0.
        rst  = 1'b0;
        mode = 1'b1;
        req  = 8'hFF;
        step("rr_first_after_reset", 3'd0, 1'b1);

        // Rotation with done each grant; done held through one idle cycle
        // (k==4) must be ignored in IDLE.
        for (int k = 1; k <= 8; k++) begin
            done = 1'b1;
            step("rr_gap", 3'd0, 1'b0);
            done = (k == 4);
            step("rr_rotate", 3'(k % 8), 1'b1);
        end
        done = 1'b0;

        // Timeout: id 0 already visible for one cycle; 3 more, then switch.
        req = 8'h81;
        for (int k = 0; k < 3; k++) step("to_hold0", 3'd0, 1'b1);
        step("to_gap0", 3'd0, 1'b0);
        for (int k = 0; k < 4; k++) step("to_hold7", 3'd7, 1'b1);
        step("to_gap7", 3'd0, 1'b0);
        step("to_back0", 3'd0, 1'b1);

        // Lone requester keeps the grant past the hold limit.
        req = 8'h00;
        step("lone_pre_idle", 3'd0, 1'b0);
        req = 8'h10;
        for (int k = 0; k < 7; k++) step("lone_hold4", 3'd4, 1'b1);
        req = 8'h00;
        step("lone_release", 3'd0, 1'b0);

        // Enable drop revokes the grant and blocks new ones.
        mode = 1'b0;
        req  = 8'h08;
        step("en_grant3", 3'd3, 1'b1);
        step("en_hold3", 3'd3, 1'b1);
        en = 1'b0;
        step("en_revoke", 3'd0, 1'b0);
        step("en_blocked_a", 3'd0, 1'b0);
        step("en_blocked_b", 3'd0, 1'b0);
        en = 1'b1;
        step("en_regrant3", 3'd3, 1'b1);

        // Mode change during a grant does not disturb it.
        mode = 1'b1;
        step("mode_change_hold", 3'd3, 1'b1);
        req = 8'h00;
        step("final_release", 3'd0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
